// File: rtl/bcd_seq_adder_pkg.sv
// Shared definitions for the sequential BCD adder: FSM state encoding and
// single-digit BCD constants.
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [4:0] BCD_MAX  = 5'd9;
  localparam logic [4:0] BCD_CORR = 5'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_seq_adder_if.sv
// Requester-side bundle for bcd_seq_adder: start/done handshake, operands
// and result. The master is the requester; the slave is the adder.
interface bcd_seq_adder_if #(parameter int DIGITS = 4);

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (output start, a, b, cin,
                  input  busy, done, sum, cout, err);

  modport slave  (input  start, a, b, cin,
                  output busy, done, sum, cout, err);

endinterface

// File: rtl/bcd_seq_adder_digit_add.sv
// Combinational single-digit BCD adder. Digits above 9 are not rejected
// here; they go through the same add-and-correct rule.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W:0] t;
  logic [DIGIT_W:0] t_corr;

  // Binary sum, then +6 correction when the result leaves the decimal range
  always_comb begin
    t      = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    t_corr = t + BCD_CORR;
    if (t > BCD_MAX) begin
      s    = t_corr[DIGIT_W-1:0];
      cout = 1'b1;
    end else begin
      s    = t[DIGIT_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// Sequential packed-BCD adder: one shared digit adder, LSD first, one digit
// per clock. Optional invalid-digit flag enabled by defining BCD_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// ADD    | processing digit k, carry held between digits
// DONE   | one-cycle done pulse, results valid and held afterwards
module bcd_seq_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bcd_seq_adder_if.slave  bus
);

  localparam int            KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int            W      = 4 * DIGITS;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_c;
  logic               accept;

  assign dig_a  = a_q[DIGIT_W*int'(k_q) +: DIGIT_W];
  assign dig_b  = b_q[DIGIT_W*int'(k_q) +: DIGIT_W];
  assign accept = (state_q == S_IDLE) && bus.start;

  bcd_digit_add u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c)
  );

  // Next-state and datapath update for the digit sequencer
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          k_d     = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[DIGIT_W*int'(k_q) +: DIGIT_W] = dig_s;
        carry_d = dig_c;
        if (k_q == K_LAST) begin
          cout_d  = dig_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any operation without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q, err_d;

  // Sticky invalid-digit flag, cleared only when a new operation is accepted
  always_comb begin
    err_d = err_q;
    if (accept)
      err_d = 1'b0;
    else if ((state_q == S_ADD) && (({1'b0, dig_a} > BCD_MAX) || ({1'b0, dig_b} > BCD_MAX)))
      err_d = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign bus.err       = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed, table-driven bench for bcd_seq_adder (DIGITS=4).
module tb_bcd_seq_adder;

  localparam int DIGITS = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd_seq_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_seq_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Run one operation; checks latency, busy profile, single done pulse and hold.
  task automatic do_op(input logic [15:0] a_i, input logic [15:0] b_i, input logic cin_i,
                       output logic [15:0] s_o, output logic c_o, output logic e_o);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a_i;
    bus.b     = b_i;
    bus.cin   = cin_i;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 16'h9999;
    bus.b     = 16'h9999;
    bus.cin   = 1'b1;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      lat++;
      @(posedge clk); #1;
    end
    check("latency", lat, DIGITS + 1);
    check("busy_cycles", busy_cnt, DIGITS);
    check("busy_at_done", bus.busy, 1'b0);
    s_o = bus.sum;
    c_o = bus.cout;
    e_o = bus.err;
    @(posedge clk); #1;
    check("done_pulse_width", bus.done, 1'b0);
    check("sum_hold", bus.sum, s_o);
  endtask

  logic [15:0] s;
  logic        c;
  logic        e;
  logic [15:0] exp_s;
  int          tot;
  int          dcnt;
  logic [15:0] cap;

  initial begin
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
    vecs[4] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h4321, 16'h1234, 1'b1, 16'h5556, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_sum",  bus.sum,  16'h0);
    check("reset_cout", bus.cout, 1'b0);
    check("reset_err",  bus.err,  1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, e);
      check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), c, vecs[i].exp_cout);
      check($sformatf("vec%0d_err", i), e, 1'b0);
    end

    // Single-digit sweep in digit 0
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        for (int ci = 0; ci < 2; ci++) begin
          tot   = x + y + ci;
          exp_s = 16'h0;
          exp_s[3:0] = 4'(tot % 10);
          exp_s[7:4] = 4'(tot / 10);
          do_op(16'(x), 16'(y), ci[0], s, c, e);
          check($sformatf("sweep_%0d_%0d_%0d_sum", x, y, ci), s, exp_s);
          check($sformatf("sweep_%0d_%0d_%0d_cout", x, y, ci), c, 1'b0);
        end
      end
    end

    // start reasserted with new operands during ADD
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h2222;
    bus.b     = 16'h3333;
    bus.cin   = 1'b0;
    @(posedge clk); #1;
    bus.a = 16'h1111;
    bus.b = 16'h1111;
    dcnt  = 0;
    cap   = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) bus.start = 1'b0;
      if (bus.done) begin
        dcnt++;
        cap = bus.sum;
      end
      @(posedge clk); #1;
    end
    check("restart_done_count", dcnt, 1);
    check("restart_sum", cap, 16'h5555);

    // Reset in the middle of ADD
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h2222;
    bus.b     = 16'h3333;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", bus.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_sum",  bus.sum,  16'h0);
    check("abort_cout", bus.cout, 1'b0);
    check("abort_err",  bus.err,  1'b0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    do_op(16'h0005, 16'h0005, 1'b0, s, c, e);
    check("post_reset_sum",  s, 16'h0010);
    check("post_reset_cout", c, 1'b0);

    // Invalid digit
    do_op(16'h00A0, 16'h0000, 1'b0, s, c, e);
    check("bad_digit_sum",  s, 16'h0100);
    check("bad_digit_cout", c, 1'b0);
`ifdef BCD_CHECK_EN
    check("bad_digit_err", e, 1'b1);
    do_op(16'h0001, 16'h0001, 1'b0, s, c, e);
    check("err_cleared", e, 1'b0);
`else
    check("bad_digit_err", e, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_seq_adder.md
# bcd_seq_adder

Sequencing controller that adds two DIGITS-wide packed-BCD operands by time-sharing one single-digit BCD adder, least-significant digit first, one digit per clock. Sits between a requester using a start/done handshake and the digit datapath. Holds the decimal carry between digits and reports the final carry-out. Replaces a wide combinational BCD chain when area matters more than latency.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  input  4*DIGITS  operand B, packed BCD
- cin  input  1  decimal carry-in to digit 0
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/cout are valid
- sum  output  4*DIGITS  packed BCD result
- cout  output  1  decimal carry out of the top digit
- err  output  1  invalid-digit flag (see Configuration)

## Operation
- States: IDLE, ADD, DONE.
- IDLE: start=1 → latch a, b, cin into operand registers, digit index k=0, carry=cin, clear sum/cout/err → ADD. start=0 → stay.
- ADD: digit adder gets a_reg[k], b_reg[k], carry; result digit written to sum[k], carry register updated; k increments. k=DIGITS-1 → cout ← digit carry, go DONE.
- DONE: done=1 for this cycle only, busy=0 → IDLE.
- Digit rule: t = a_k + b_k + carry (5-bit); t>9 → digit = t+6 mod 16, carry=1; else digit = t, carry=0.
- start while busy or in DONE is ignored; operands are not re-latched. Input changes after acceptance have no effect.
- sum, cout, err hold their values from done until the next accepted start.
- Reset (any state, including mid-ADD): state=IDLE, k=0, carry=0; sum=0, cout=0, done=0, busy=0, err=0. No done is issued for an aborted operation.

## Timing
- Cycle 0: start high at edge in IDLE → accepted.
- Cycles 1..DIGITS: ADD, busy=1, digit k=c-1 processed.
- Cycle DIGITS+1: DONE, done=1, sum/cout valid; busy=0.
- Latency start→done = DIGITS+1 cycles; throughput one op per DIGITS+2 cycles (start can be accepted the cycle after DONE).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- BCD_CHECK_EN defined: in ADD, any operand digit >9 sets err (sticky until next accepted start); operation still completes with the raw digit rule and done pulses normally.
- BCD_CHECK_EN undefined: err tied 0; no checking logic.

## Structure
- Package bcd_pkg: state enum (IDLE, ADD, DONE), DIGIT_W=4, BCD_MAX=9, BCD_CORR=6.
- Sub-module bcd_digit_add: combinational one-digit adder (a, b, cin → s, cout) using the digit rule; instantiated once, muxed by k.
- Digit index width $clog2(DIGITS), min 1.

## Test plan
- DIGITS=4, a=1234, b=5678, cin=0, start pulse → done 5 cycles later, sum=6912, cout=0, busy high cycles 1–4.
- a=9999, b=0001, cin=0 → sum=0000, cout=1 (carry ripple through all digits).
- a=0000, b=0000, cin=1 → sum=0001, cout=0; then exhaustive single-digit sweep 0–9 × 0–9 × cin in digit 0 against a+b+cin.
- start reasserted with a=1111 during ADD of 2222+3333 → result 5555, only one done pulse.
- reset asserted at cycle 2 of an op → all outputs 0 immediately, state IDLE, no done; next start 0005+0005 → 0010.
- BCD_CHECK_EN: a=00A0, b=0000 → err=1 at done; without macro err=0.
